dio_multi_pulse_gen: RTL and testbench

- Multi-channel, time-triggered pulse generator for the WR DIO core. Successor to the fixed 5-channel DIO trigger logic.
- Each of g_num_channels channels is armed with an absolute TAI trigger time (seconds + cycles). When the WR time reaches that value, the channel drives a programmable-width pulse.
- Sits between the DIO Wishbone register bank (cfg_* side) and the output buffers (pulse_o).
- Adds per-channel late detection and cancel.

---
 rtl/dio_multi_pulse_gen.sv | 194 +++++++++++++++++++
 tb/tb_dio_multi_pulse_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dio_multi_pulse_gen.sv
// dio_multi_pulse_gen: per-channel TAI-time-triggered pulse generator with late detection and cancel.
// Latency: armed_o/cfg_err_o one cycle after the cfg strobe; pulse_o rises one cycle after the time compare hits.
// Backpressure: none; writes to a channel in PULSE are refused with cfg_err_o. Macro DIO_PERIODIC_EN adds periodic repeat.
module dio_multi_pulse_gen #(
  parameter int g_num_channels     = 5,
  parameter int g_seconds_width    = 40,
  parameter int g_cycles_width     = 28,
  parameter int g_cycles_per_sec   = 125000000,
  parameter int g_pulse_width_bits = 28
) (
  input  logic                                  clk_sys_i,
  input  logic                                  rst_n_i,
  input  logic                                  tm_time_valid_i,
  input  logic [g_seconds_width-1:0]            tm_seconds_i,
  input  logic [g_cycles_width-1:0]             tm_cycles_i,
  input  logic                                  cfg_wr_i,
  input  logic                                  cfg_cancel_i,
  input  logic [((g_num_channels > 1) ? $clog2(g_num_channels) : 1)-1:0] cfg_ch_i,
  input  logic [g_seconds_width-1:0]            cfg_seconds_i,
  input  logic [g_cycles_width-1:0]             cfg_cycles_i,
  input  logic [g_pulse_width_bits-1:0]         cfg_width_i,
  input  logic [g_cycles_width-1:0]             cfg_period_i,
  input  logic [15:0]                           cfg_count_i,
  output logic                                  cfg_err_o,
  output logic [g_num_channels-1:0]             armed_o,
  output logic [g_num_channels-1:0]             pulse_o,
  output logic [g_num_channels-1:0]             done_o,
  output logic [g_num_channels-1:0]             late_o,
  input  logic [g_num_channels-1:0]             late_clr_i
);

  localparam int CH_W = (g_num_channels > 1) ? $clog2(g_num_channels) : 1;
  localparam int NPAD = 1 << CH_W;
  localparam int SW   = g_seconds_width;
  localparam int CW   = g_cycles_width;
  localparam int PW   = g_pulse_width_bits;
  localparam logic [CW:0]   MOD_X = (CW+1)'(g_cycles_per_sec);
  localparam logic [CH_W:0] NCH_X = (CH_W+1)'(g_num_channels);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_PULSE} state_t;

  logic [SW+CW-1:0]          now_t;
  logic [PW-1:0]             eff_width;
  logic                      cyc_bad, ch_bad, busy_bad, per_bad, wr_ok, cancel_ok;
  logic [g_num_channels-1:0] in_pulse;
  logic [NPAD-1:0]           in_pulse_pad;

  assign now_t        = {tm_seconds_i, tm_cycles_i};
  assign eff_width    = (cfg_width_i == '0) ? PW'(1) : cfg_width_i;
  assign cyc_bad      = ({1'b0, cfg_cycles_i} >= MOD_X);
  assign ch_bad       = ({1'b0, cfg_ch_i} >= NCH_X);
  assign in_pulse_pad = NPAD'(in_pulse);
  // Out-of-range channels land in the zero padding, so they never read as busy.
  assign busy_bad     = in_pulse_pad[cfg_ch_i];

`ifdef DIO_PERIODIC_EN
  localparam int MW = (CW > PW) ? CW : PW;
  logic [MW-1:0] per_x, wid_x;
  assign per_x   = MW'(cfg_period_i);
  assign wid_x   = MW'(eff_width);
  // A period not longer than the pulse would make consecutive pulses overlap.
  assign per_bad = (cfg_period_i != '0) && (per_x <= wid_x);
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_period_i, cfg_count_i};
  assign per_bad    = 1'b0;
`endif

  assign cancel_ok = cfg_cancel_i && !ch_bad;
  // A simultaneous cancel always beats the write.
  assign wr_ok     = cfg_wr_i && !(cyc_bad || ch_bad || busy_bad || cfg_cancel_i || per_bad);

  // One-cycle error strobe for every refused write
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) cfg_err_o <= 1'b0;
    else          cfg_err_o <= cfg_wr_i && !wr_ok;
  end

  for (genvar g = 0; g < g_num_channels; g++) begin : g_ch
    state_t           st;
    logic [SW-1:0]    trig_s;
    logic [CW-1:0]    trig_c;
    logic [PW-1:0]    width, rem;
    logic [SW+CW-1:0] trig_t;
    logic             first, last_q, last_new, sel, wr_hit, cancel_hit, hit, late_evt;
    logic             armed_q, pulse_q, done_q, late_q;

    assign sel        = (cfg_ch_i == CH_W'(g));
    assign wr_hit     = wr_ok && sel;
    assign cancel_hit = cancel_ok && sel;
    assign trig_t     = {trig_s, trig_c};
    // The first valid compare after arming fires only on an exact match; afterwards any
    // time at or past the trigger fires, covering valid gaps and time jumps.
    assign hit        = tm_time_valid_i && (first ? (now_t == trig_t) : (now_t >= trig_t));
    assign late_evt   = (st == ST_ARMED) && !cancel_hit && !wr_hit && tm_time_valid_i &&
                        first && (now_t > trig_t);
    assign in_pulse[g] = (st == ST_PULSE);
    assign armed_o[g]  = armed_q;
    assign pulse_o[g]  = pulse_q;
    assign done_o[g]   = done_q;
    assign late_o[g]   = late_q;

`ifdef DIO_PERIODIC_EN
    logic [CW-1:0] period_q, c_next;
    logic [15:0]   cnt_left;
    logic          inf_q, c_wrap;
    logic [CW:0]   c_sum;
    assign c_sum    = {1'b0, trig_c} + {1'b0, period_q};
    assign c_wrap   = (c_sum >= MOD_X);
    assign c_next   = c_wrap ? CW'(c_sum - MOD_X) : CW'(c_sum);
    assign last_new = (period_q == '0) || (!inf_q && (cnt_left == 16'd1));
`else
    assign last_new = 1'b1;
`endif

    // Channel FSM: arm/cancel from the register side, time compare, pulse timing
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        st      <= ST_IDLE;
        trig_s  <= '0;
        trig_c  <= '0;
        width   <= '0;
        rem     <= '0;
        first   <= 1'b0;
        last_q  <= 1'b0;
        armed_q <= 1'b0;
        pulse_q <= 1'b0;
        done_q  <= 1'b0;
        late_q  <= 1'b0;
`ifdef DIO_PERIODIC_EN
        period_q <= '0;
        cnt_left <= '0;
        inf_q    <= 1'b0;
`endif
      end else begin
        done_q <= 1'b0;
        late_q <= late_evt | (late_q & ~late_clr_i[g]);
        if (cancel_hit) begin
          st      <= ST_IDLE;
          armed_q <= 1'b0;
          pulse_q <= 1'b0;
        end else if (wr_hit) begin
          st      <= ST_ARMED;
          armed_q <= 1'b1;
          trig_s  <= cfg_seconds_i;
          trig_c  <= cfg_cycles_i;
          width   <= eff_width;
          first   <= 1'b1;
`ifdef DIO_PERIODIC_EN
          period_q <= cfg_period_i;
          cnt_left <= cfg_count_i;
          inf_q    <= (cfg_count_i == '0);
`endif
        end else begin
          case (st)
            ST_ARMED: if (tm_time_valid_i) begin
              first <= 1'b0;
              if (late_evt) begin
                st      <= ST_IDLE;
                armed_q <= 1'b0;
              end else if (hit) begin
                st      <= ST_PULSE;
                armed_q <= 1'b0;
                pulse_q <= 1'b1;
                rem     <= width;
                last_q  <= last_new;
                done_q  <= (width == PW'(1)) && last_new;
`ifdef DIO_PERIODIC_EN
                trig_c <= c_next;
                if (c_wrap) trig_s <= trig_s + SW'(1);
                if (!inf_q) cnt_left <= cnt_left - 16'd1;
`endif
              end
            end
            ST_PULSE: if (rem == PW'(1)) begin
              pulse_q <= 1'b0;
              if (last_q) begin
                st <= ST_IDLE;
              end else begin
                st      <= ST_ARMED;
                armed_q <= 1'b1;
              end
            end else begin
              rem    <= rem - PW'(1);
              done_q <= (rem == PW'(2)) && last_q;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dio_multi_pulse_gen.sv
// tb_dio_multi_pulse_gen: directed bench for dio_multi_pulse_gen with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
// A small monitor records per-channel pulse starts, pulse lengths and done_o positions.
module tb_dio_multi_pulse_gen;
  localparam int NCH = 5;
  localparam int MOD = 125000000;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        tm_time_valid;
  logic [39:0] tm_seconds;
  logic [27:0] tm_cycles;
  logic        cfg_wr, cfg_cancel;
  logic [2:0]  cfg_ch;
  logic [39:0] cfg_seconds;
  logic [27:0] cfg_cycles, cfg_width, cfg_period;
  logic [15:0] cfg_count;
  logic        cfg_err;
  logic [NCH-1:0] armed, pulse, done, late, late_clr;
  logic        tm_run;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt [NCH];
  int done_cnt  [NCH];
  int done_at   [NCH];
  int nstart    [NCH];
  logic [67:0] starts [NCH][4];
  logic [NCH-1:0] pulse_prev;
  logic found;

  always #4 clk_sys = ~clk_sys;

  dio_multi_pulse_gen dut (
    .clk_sys_i       (clk_sys),
    .rst_n_i         (rst_n),
    .tm_time_valid_i (tm_time_valid),
    .tm_seconds_i    (tm_seconds),
    .tm_cycles_i     (tm_cycles),
    .cfg_wr_i        (cfg_wr),
    .cfg_cancel_i    (cfg_cancel),
    .cfg_ch_i        (cfg_ch),
    .cfg_seconds_i   (cfg_seconds),
    .cfg_cycles_i    (cfg_cycles),
    .cfg_width_i     (cfg_width),
    .cfg_period_i    (cfg_period),
    .cfg_count_i     (cfg_count),
    .cfg_err_o       (cfg_err),
    .armed_o         (armed),
    .pulse_o         (pulse),
    .done_o          (done),
    .late_o          (late),
    .late_clr_i      (late_clr)
  );

  task automatic check_val(input string tag, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic clr_mon();
    for (int i = 0; i < NCH; i++) begin
      pulse_cnt[i] = 0;
      done_cnt[i]  = 0;
      done_at[i]   = 0;
      nstart[i]    = 0;
      for (int k = 0; k < 4; k++) starts[i][k] = '0;
    end
  endtask

  // Advance to the next falling edge, record what the DUT shows, then move WR time on.
  task automatic tick();
    @(negedge clk_sys);
    for (int i = 0; i < NCH; i++) begin
      if (pulse[i]) begin
        pulse_cnt[i]++;
        if (!pulse_prev[i]) begin
          if (nstart[i] < 4) starts[i][nstart[i]] = {tm_seconds, tm_cycles};
          nstart[i]++;
        end
      end
      if (done[i]) begin
        done_cnt[i]++;
        done_at[i] = pulse[i] ? pulse_cnt[i] : 999;
      end
    end
    pulse_prev = pulse;
    if (tm_run) begin
      if (tm_cycles == 28'(MOD - 1)) begin
        tm_cycles  = '0;
        tm_seconds = tm_seconds + 40'd1;
      end else begin
        tm_cycles = tm_cycles + 28'd1;
      end
    end
  endtask

  task automatic arm(input int ch, input logic [39:0] s, input logic [27:0] c, input logic [27:0] w);
    cfg_ch      = 3'(ch);
    cfg_seconds = s;
    cfg_cycles  = c;
    cfg_width   = w;
    cfg_wr      = 1'b1;
    tick();
    cfg_wr      = 1'b0;
  endtask

  task automatic wait_pulse(input int ch, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      tick();
      if (pulse[ch]) ok = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; tm_time_valid = 1'b0; tm_seconds = '0; tm_cycles = '0; tm_run = 1'b0;
    cfg_wr = 1'b0; cfg_cancel = 1'b0; cfg_ch = '0; cfg_seconds = '0; cfg_cycles = '0;
    cfg_width = '0; cfg_period = '0; cfg_count = '0; late_clr = '0; pulse_prev = '0;
    clr_mon();
    tick(); tick();
    check_val("rst_pulse", pulse, 0);
    check_val("rst_armed", armed, 0);
    check_val("rst_done",  done, 0);
    check_val("rst_late",  late, 0);
    check_val("rst_err",   cfg_err, 0);
    rst_n = 1'b1;
    tm_seconds = 40'd1; tm_cycles = '0; tm_time_valid = 1'b1; tm_run = 1'b1;
    tick();

    // Basic single shot on ch0
    clr_mon();
    arm(0, 40'd2, 28'd1000, 28'd10);
    check_val("t1_err", cfg_err, 0);
    check_val("t1_armed", armed[0], 1);
    tick();
    tm_seconds = 40'd2; tm_cycles = 28'd990;
    repeat (30) tick();
    check_val("t1_nstart", nstart[0], 1);
    check_val("t1_start_time", starts[0][0], {40'd2, 28'd1000});
    check_val("t1_len", pulse_cnt[0], 10);
    check_val("t1_done_cnt", done_cnt[0], 1);
    check_val("t1_done_pos", done_at[0], 10);
    check_val("t1_idle", armed[0], 0);
    check_val("t1_late", late[0], 0);

    // Late trigger on ch1
    clr_mon();
    tm_seconds = 40'd1; tm_cycles = 28'd200;
    arm(1, 40'd1, 28'd50, 28'd3);
    check_val("t2_armed", armed[1], 1);
    tick();
    check_val("t2_armed_drop", armed[1], 0);
    check_val("t2_late_set", late, 5'b00010);
    repeat (5) tick();
    check_val("t2_late_sticky", late[1], 1);
    check_val("t2_no_pulse", pulse_cnt[1], 0);
    check_val("t2_no_done", done_cnt[1], 0);
    late_clr = 5'b00010;
    tick();
    late_clr = '0;
    check_val("t2_late_clr", late[1], 0);

    // Cancel while ARMED on ch2
    clr_mon();
    arm(2, 40'd3, 28'd0, 28'd4);
    check_val("t3_armed", armed[2], 1);
    cfg_ch = 3'd2; cfg_cancel = 1'b1;
    tick();
    cfg_cancel = 1'b0;
    check_val("t3_disarm", armed[2], 0);
    check_val("t3_err", cfg_err, 0);
    tm_seconds = 40'd2; tm_cycles = 28'(MOD - 5);
    repeat (20) tick();
    check_val("t3_no_pulse", pulse_cnt[2], 0);
    check_val("t3_no_done", done_cnt[2], 0);

    // Cancel while PULSE on ch4
    clr_mon();
    tm_seconds = 40'd5; tm_cycles = 28'd100;
    arm(4, 40'd5, 28'd105, 28'd20);
    wait_pulse(4, found);
    check_val("t3b_pulse_seen", found, 1);
    repeat (3) tick();
    cfg_ch = 3'd4; cfg_cancel = 1'b1;
    tick();
    cfg_cancel = 1'b0;
    check_val("t3b_pulse_drop", pulse[4], 0);
    check_val("t3b_armed", armed[4], 0);
    repeat (25) tick();
    check_val("t3b_len", pulse_cnt[4], 4);
    check_val("t3b_no_done", done_cnt[4], 0);

    // Rejected writes
    clr_mon();
    arm(3, 40'd9, 28'(MOD), 28'd4);
    check_val("t4a_err", cfg_err, 1);
    check_val("t4a_state", armed, 0);
    tick();
    check_val("t4a_err_once", cfg_err, 0);
    arm(7, 40'd9, 28'd0, 28'd4);
    check_val("t4b_err", cfg_err, 1);
    check_val("t4b_state", armed, 0);
    tm_seconds = 40'd6; tm_cycles = 28'd0;
    arm(0, 40'd6, 28'd3, 28'd10);
    check_val("t4c_arm_ok", cfg_err, 0);
    wait_pulse(0, found);
    check_val("t4c_pulse_seen", found, 1);
    tick();
    arm(0, 40'd7, 28'd0, 28'd1);
    check_val("t4c_err", cfg_err, 1);
    check_val("t4c_pulse_kept", pulse[0], 1);
    check_val("t4c_not_armed", armed[0], 0);
    repeat (20) tick();
    check_val("t4c_len", pulse_cnt[0], 10);
    check_val("t4c_done", done_cnt[0], 1);
    check_val("t4c_idle", armed[0], 0);
    cfg_cancel = 1'b1;
    arm(3, 40'd9, 28'd0, 28'd4);
    cfg_cancel = 1'b0;
    check_val("t4d_err", cfg_err, 1);
    check_val("t4d_state", armed[3], 0);

    // Valid gap across the trigger on ch3
    clr_mon();
    tm_seconds = 40'd8; tm_cycles = 28'd0;
    arm(3, 40'd8, 28'd10, 28'd4);
    tick();
    tm_time_valid = 1'b0;
    repeat (29) tick();
    check_val("t5_hold_no_pulse", pulse_cnt[3], 0);
    check_val("t5_hold_armed", armed[3], 1);
    tm_time_valid = 1'b1;
    tick();
    check_val("t5_fire", pulse[3], 1);
    repeat (10) tick();
    check_val("t5_start_time", starts[3][0], {40'd8, 28'd31});
    check_val("t5_len", pulse_cnt[3], 4);
    check_val("t5_done_pos", done_at[3], 4);
    check_val("t5_late", late[3], 0);

`ifdef DIO_PERIODIC_EN
    // Periodic: three pulses across a second boundary on ch1
    clr_mon();
    tm_seconds = 40'd1; tm_cycles = 28'(MOD - 20);
    cfg_period = 28'd20; cfg_count = 16'd3;
    arm(1, 40'd1, 28'(MOD - 10), 28'd5);
    check_val("t6_err", cfg_err, 0);
    cfg_period = '0; cfg_count = '0;
    repeat (70) tick();
    check_val("t6_nstart", nstart[1], 3);
    check_val("t6_start0", starts[1][0], {40'd1, 28'(MOD - 10)});
    check_val("t6_start1", starts[1][1], {40'd2, 28'd10});
    check_val("t6_start2", starts[1][2], {40'd2, 28'd30});
    check_val("t6_len", pulse_cnt[1], 15);
    check_val("t6_done_cnt", done_cnt[1], 1);
    check_val("t6_done_pos", done_at[1], 15);
    check_val("t6_idle", armed[1], 0);
    cfg_period = 28'd5;
    arm(2, 40'd9, 28'd0, 28'd5);
    cfg_period = '0;
    check_val("t7_err", cfg_err, 1);
    check_val("t7_state", armed[2], 0);
`else
    // Without the periodic option the period field is ignored
    cfg_period = 28'd5;
    arm(2, 40'd9, 28'd0, 28'd5);
    cfg_period = '0;
    check_val("t7_period_ignored", cfg_err, 0);
    check_val("t7_armed", armed[2], 1);
    cfg_ch = 3'd2; cfg_cancel = 1'b1;
    tick();
    cfg_cancel = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
